branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/riscv_branch_pkg.sv | 28 ++
 rtl/branch_resolve_if.sv | 37 +++
 rtl/branch_bht.sv | 38 +++
 rtl/branch_resolve.sv | 115 +++++++++++
 tb/tb_branch_resolve.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/riscv_branch_pkg.sv
// Shared constants for branch resolution: funct3 branch conditions, 2-bit
// predictor counter states and the saturating counter step.
package riscv_branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic taken;
    logic mispredict;
    logic illegal;
  } br_flags_t;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == ST)  ? ST  : cnt + 2'd1;
    else    return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Request/response and prediction-lookup bundle for branch_resolve.
// slave is the resolver side, master is the issuing/consuming side.
interface branch_resolve_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] imm;
  logic [2:0]      funct3;
  logic            pred_taken_in;
  logic            flush;
  logic [XLEN-1:0] lookup_pc;
  logic            lookup_taken;
  logic            out_valid;
  logic            out_ready;
  logic            taken;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic            illegal;
  logic [31:0]     br_count;
  logic [31:0]     mp_count;

  modport slave (
    input  in_valid, pc, rs1, rs2, imm, funct3, pred_taken_in, flush,
           lookup_pc, out_ready,
    output in_ready, lookup_taken, out_valid, taken, mispredict,
           redirect_pc, illegal, br_count, mp_count
  );

  modport master (
    output in_valid, pc, rs1, rs2, imm, funct3, pred_taken_in, flush,
           lookup_pc, out_ready,
    input  in_ready, lookup_taken, out_valid, taken, mispredict,
           redirect_pc, illegal, br_count, mp_count
  );
endinterface

// File: rtl/branch_bht.sv
// Branch history table: BHT_ENTRIES 2-bit saturating counters with a
// combinational lookup port and one registered update port.
module branch_bht
  import riscv_branch_pkg::*;
#(
  parameter  int         BHT_ENTRIES = 64,
  parameter  logic [1:0] BHT_INIT    = 2'b01,
  localparam int         IDXW        = $clog2(BHT_ENTRIES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IDXW-1:0] lookup_idx,
  output logic            lookup_taken,
  input  logic            upd_en,
  input  logic [IDXW-1:0] upd_idx,
  input  logic            upd_taken
);

  logic [1:0] cnt_q [BHT_ENTRIES];
  logic [1:0] cnt_d [BHT_ENTRIES];

  always_comb begin
    cnt_d = cnt_q;
    if (upd_en) cnt_d[upd_idx] = sat_step(cnt_q[upd_idx], upd_taken);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) cnt_q[i] <= BHT_INIT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Reads the registered array, so a same-edge update is not visible yet.
  assign lookup_taken = cnt_q[lookup_idx][1];

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution stage: evaluates the funct3 condition, computes the next
// PC, registers the result behind a valid/ready handshake and trains the BHT.
module branch_resolve
  import riscv_branch_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] BHT_INIT    = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  branch_resolve_if.slave  bus
);

  localparam int IDXW = $clog2(BHT_ENTRIES);

  logic            out_valid_q, out_valid_d;
  br_flags_t       flags_q, flags_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [31:0]     br_count_q, br_count_d;
  logic [31:0]     mp_count_q, mp_count_d;

  logic            accept;
  logic            cond;
  logic            legal;
  logic            upd_en;
  br_flags_t       flags_new;
  logic [XLEN-1:0] target_pc;

  assign bus.in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    unique case (bus.funct3)
      F3_BEQ:  cond = (bus.rs1 == bus.rs2);
      F3_BNE:  cond = (bus.rs1 != bus.rs2);
      F3_BLT:  cond = ($signed(bus.rs1) <  $signed(bus.rs2));
      F3_BGE:  cond = ($signed(bus.rs1) >= $signed(bus.rs2));
      F3_BLTU: cond = (bus.rs1 <  bus.rs2);
      F3_BGEU: cond = (bus.rs1 >= bus.rs2);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    flags_new.taken      = cond;
    flags_new.illegal    = !legal;
    flags_new.mispredict = legal && (cond != bus.pred_taken_in);
    target_pc = cond ? (bus.pc + bus.imm) : (bus.pc + XLEN'(4));
  end

  // Illegal encodings still produce a result but leave BHT and counters alone.
  assign upd_en = accept && legal;

  always_comb begin
    out_valid_d   = out_valid_q;
    flags_d       = flags_q;
    redirect_pc_d = redirect_pc_q;
    br_count_d    = br_count_q;
    mp_count_d    = mp_count_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      flags_d       = flags_new;
      redirect_pc_d = target_pc;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (upd_en) begin
      br_count_d = br_count_q + 32'd1;
      if (flags_new.mispredict) mp_count_d = mp_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      flags_q       <= '0;
      redirect_pc_q <= '0;
      br_count_q    <= '0;
      mp_count_q    <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      flags_q       <= flags_d;
      redirect_pc_q <= redirect_pc_d;
      br_count_q    <= br_count_d;
      mp_count_q    <= mp_count_d;
    end
  end

  branch_bht #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .BHT_INIT    (BHT_INIT)
  ) u_bht (
    .clk          (clk),
    .rst          (rst),
    .lookup_idx   (bus.lookup_pc[IDXW+1:2]),
    .lookup_taken (bus.lookup_taken),
    .upd_en       (upd_en),
    .upd_idx      (bus.pc[IDXW+1:2]),
    .upd_taken    (cond)
  );

  assign bus.out_valid   = out_valid_q;
  assign bus.taken       = flags_q.taken;
  assign bus.mispredict  = flags_q.mispredict;
  assign bus.illegal     = flags_q.illegal;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.br_count    = br_count_q;
  assign bus.mp_count    = mp_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: reset state, condition decode, BHT
// training, backpressure, flush, illegal funct3, PC wrap and async reset.
module tb_branch_resolve;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  branch_resolve_if #(.XLEN(32)) bif ();

  branch_resolve #(.XLEN(32), .BHT_ENTRIES(64), .BHT_INIT(2'b01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] i, input logic [2:0] f, input logic pr);
    bif.pc = p; bif.rs1 = a; bif.rs2 = b; bif.imm = i;
    bif.funct3 = f; bif.pred_taken_in = pr;
  endtask

  task automatic issue(input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] i, input logic [2:0] f, input logic pr);
    set_req(p, a, b, i, f, pr);
    bif.in_valid = 1'b1;
    step();
    bif.in_valid = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic tk, input logic mp,
                         input logic il, input logic [31:0] rpc);
    chk({tag, ".valid"},    32'(bif.out_valid),  32'd1);
    chk({tag, ".taken"},    32'(bif.taken),      32'(tk));
    chk({tag, ".mispred"},  32'(bif.mispredict), 32'(mp));
    chk({tag, ".illegal"},  32'(bif.illegal),    32'(il));
    chk({tag, ".redirect"}, bif.redirect_pc,     rpc);
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] br, input logic [31:0] mp);
    chk({tag, ".br_count"}, bif.br_count, br);
    chk({tag, ".mp_count"}, bif.mp_count, mp);
  endtask

  initial begin
    bif.in_valid = 1'b0; bif.out_ready = 1'b1; bif.flush = 1'b0;
    bif.lookup_pc = 32'h0;
    set_req(32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0);

    // Reset state
    step(); step();
    chk("rst.valid", 32'(bif.out_valid), 32'd0);
    chk("rst.taken", 32'(bif.taken), 32'd0);
    chk("rst.mispred", 32'(bif.mispredict), 32'd0);
    chk("rst.illegal", 32'(bif.illegal), 32'd0);
    chk("rst.redirect", bif.redirect_pc, 32'h0);
    chk_cnt("rst", 32'd0, 32'd0);
    chk("rst.lookup", 32'(bif.lookup_taken), 32'd0);
    #2 rst = 1'b0;

    // Signed vs unsigned less-than on the same operands
    issue(32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 3'b100, 1'b0);
    chk_res("blt", 1'b1, 1'b1, 1'b0, 32'h120);
    chk_cnt("blt", 32'd1, 32'd1);
    issue(32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 3'b110, 1'b0);
    chk_res("bltu", 1'b0, 1'b0, 1'b0, 32'h104);
    chk_cnt("bltu", 32'd2, 32'd1);

    // BHT training at 0x40 (idx 16): 1 -> 2 -> 3 -> 3 -> 2 -> 1
    bif.lookup_pc = 32'h40;
    chk("bht.init", 32'(bif.lookup_taken), 32'd0);
    issue(32'h40, 32'd5, 32'd5, 32'h10, 3'b000, 1'b0);
    chk_res("beq1", 1'b1, 1'b1, 1'b0, 32'h50);
    chk("bht.1", 32'(bif.lookup_taken), 32'd1);
    issue(32'h40, 32'd5, 32'd5, 32'h10, 3'b000, 1'b1);
    chk("bht.2", 32'(bif.lookup_taken), 32'd1);
    issue(32'h40, 32'd5, 32'd5, 32'h10, 3'b000, 1'b1);
    chk("bht.3", 32'(bif.lookup_taken), 32'd1);
    issue(32'h40, 32'd5, 32'd6, 32'h10, 3'b000, 1'b1);
    chk_res("beq4", 1'b0, 1'b1, 1'b0, 32'h44);
    chk("bht.4", 32'(bif.lookup_taken), 32'd1);
    issue(32'h40, 32'd5, 32'd6, 32'h10, 3'b000, 1'b0);
    chk("bht.5", 32'(bif.lookup_taken), 32'd0);
    chk_cnt("beq5", 32'd7, 32'd3);

    // Drain with no new request
    step();
    chk("drain.valid", 32'(bif.out_valid), 32'd0);

    // Backpressure: signed BGE taken with negative offset held for 5 cycles
    bif.out_ready = 1'b0;
    issue(32'h200, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFF0, 3'b101, 1'b1);
    set_req(32'h300, 32'd1, 32'd1, 32'h40, 3'b001, 1'b0);
    bif.in_valid = 1'b1;
    #1;
    chk("bp.in_ready", 32'(bif.in_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk_res("bp.hold", 1'b1, 1'b0, 1'b0, 32'h1F0);
    end
    chk_cnt("bp.hold", 32'd8, 32'd3);
    bif.out_ready = 1'b1;
    #1;
    chk("bp.in_ready1", 32'(bif.in_ready), 32'd1);
    step();
    bif.in_valid = 1'b0;
    chk_res("bp.bne", 1'b0, 1'b0, 1'b0, 32'h304);
    chk_cnt("bp.bne", 32'd9, 32'd3);

    // Flush in the cycle after acceptance blocks a competing request
    bif.lookup_pc = 32'h80;
    issue(32'h80, 32'd5, 32'd5, 32'h8, 3'b111, 1'b1);
    chk_res("bgeu", 1'b1, 1'b0, 1'b0, 32'h88);
    chk("bgeu.lookup", 32'(bif.lookup_taken), 32'd1);
    set_req(32'h80, 32'd5, 32'd5, 32'h8, 3'b001, 1'b1);
    bif.in_valid = 1'b1; bif.flush = 1'b1;
    #1;
    chk("flush.in_ready", 32'(bif.in_ready), 32'd0);
    step();
    bif.in_valid = 1'b0; bif.flush = 1'b0;
    chk("flush.valid", 32'(bif.out_valid), 32'd0);
    chk_cnt("flush", 32'd10, 32'd3);
    chk("flush.lookup", 32'(bif.lookup_taken), 32'd1);

    // Illegal funct3 and PC wrap
    issue(32'h500, 32'd7, 32'd7, 32'h10, 3'b010, 1'b1);
    chk_res("illegal", 1'b0, 1'b0, 1'b1, 32'h504);
    chk_cnt("illegal", 32'd10, 32'd3);
    issue(32'hFFFF_FFFC, 32'd9, 32'd9, 32'h8, 3'b000, 1'b1);
    chk_res("wrap", 1'b1, 1'b0, 1'b0, 32'h4);
    chk_cnt("wrap", 32'd11, 32'd3);

    // Async reset mid-cycle clears pending result and BHT without an edge
    #3 rst = 1'b1;
    #1;
    chk("arst.valid", 32'(bif.out_valid), 32'd0);
    chk_cnt("arst", 32'd0, 32'd0);
    chk("arst.lookup", 32'(bif.lookup_taken), 32'd0);
    #1 rst = 1'b0;
    issue(32'h40, 32'd1, 32'd1, 32'h10, 3'b000, 1'b0);
    chk_res("post_rst", 1'b1, 1'b1, 1'b0, 32'h50);
    chk_cnt("post_rst", 32'd1, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
